// File: rtl/mcu_cmd_bridge.sv
// Host-register to SPI command bridge with TX/RX byte FIFOs.
// Optional macro MCU_CMD_BRIDGE_TIMEOUT_EN: abandon a transfer after 4095 WAIT cycles.

module mcu_cmd_bridge_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [7:0]                 wdata_i,
    output logic [7:0]                 rdata_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok, push_ok;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign pop_ok  = pop_i & (cnt_q != '0);
    assign push_ok = push_i & ((cnt_q != CW'(DEPTH)) | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
endmodule

module mcu_cmd_bridge #(
    parameter int MAX_LEN    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       SClk,
    input  logic       nReset,
    input  logic       WrStrobe,
    input  logic       RdStrobe,
    input  logic       SelCtrl,
    input  logic       SelLen,
    input  logic       SelData,
    input  logic [7:0] WriteData,
    output logic [7:0] ReadData,
    input  logic       SPIDi,
    output logic       SPIDo,
    output logic       nMCUSel,
    output logic       SPIClkRunning,
    output logic       SPIClkStretch
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOWER_CS, S_CMD, S_DATA, S_WAIT, S_RAISE_CS
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    bytes_left_q, bytes_left_d;
    logic [3:0]    remaining;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          cs_n_q, cs_n_d;
    logic          err_q, err_d;

    logic          is_idle, is_read, start_ok, flush;
    logic          tx_push, tx_pop, tx_empty, tx_full, tx_drop;
    logic          rx_push, rx_pop, rx_pop_ok, rx_empty, rx_underflow, rx_full_next;
    logic [CW-1:0] tx_count, rx_count, rx_cnt_next;
    logic [7:0]    tx_head, rx_head, byte_load, status;
    logic [3:0]    len_sat;
    logic          byte_ready, timeout_hit;

    assign is_idle  = (state_q == S_IDLE);
    assign is_read  = cmd_q[0];
    assign start_ok = WrStrobe & SelCtrl & WriteData[4] & (WriteData[3:1] < 3'd6) & is_idle;
    assign flush    = WrStrobe & SelCtrl & WriteData[7] & is_idle;
    assign len_sat  = (WriteData[3:0] > 4'(MAX_LEN)) ? 4'(MAX_LEN) : WriteData[3:0];

    assign tx_push      = WrStrobe & SelData;
    assign tx_empty     = (tx_count == '0);
    assign tx_full      = (tx_count == CW'(FIFO_DEPTH));
    assign tx_drop      = tx_push & tx_full & ~tx_pop;

    assign rx_pop       = RdStrobe & SelData;
    assign rx_empty     = (rx_count == '0);
    assign rx_pop_ok    = rx_pop & ~rx_empty;
    assign rx_underflow = rx_pop & rx_empty;
    assign rx_push      = (state_q == S_DATA) & is_read & (bit_cnt_q == 3'd7);
    // Fullness after this cycle's push/pop decides whether the next read byte may start.
    assign rx_cnt_next  = rx_count + CW'(rx_push) - CW'(rx_pop_ok);
    assign rx_full_next = (rx_cnt_next == CW'(FIFO_DEPTH));

    assign byte_ready = is_read ? ~rx_full_next : ~tx_empty;
    assign byte_load  = is_read ? 8'hFF : tx_head;

    mcu_cmd_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (SClk),
        .rst_n   (nReset),
        .flush_i (flush),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (WriteData),
        .rdata_o (tx_head),
        .count_o (tx_count)
    );

    mcu_cmd_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (SClk),
        .rst_n   (nReset),
        .flush_i (flush),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .wdata_i ({shift_q[6:0], SPIDi}),
        .rdata_o (rx_head),
        .count_o (rx_count)
    );

`ifdef MCU_CMD_BRIDGE_TIMEOUT_EN
    logic [11:0] wait_cnt_q;

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset)                wait_cnt_q <= '0;
        else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + 12'd1;
        else                        wait_cnt_q <= '0;
    end

    // The 4095th consecutive stalled cycle gives up on the transfer.
    assign timeout_hit = (state_q == S_WAIT) & (wait_cnt_q == 12'd4094) & ~byte_ready;
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        bytes_left_d = bytes_left_q;
        cs_n_d       = cs_n_q;
        tx_pop       = 1'b0;
        remaining    = bytes_left_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d      = S_LOWER_CS;
                    cmd_d        = WriteData[3:0];
                    bytes_left_d = len_q;
                end
            end
            S_LOWER_CS: begin
                shift_d   = {4'hF, cmd_q};
                bit_cnt_d = 3'd0;
                cs_n_d    = 1'b0;
                state_d   = S_CMD;
            end
            S_CMD, S_DATA: begin
                shift_d   = {shift_q[6:0], SPIDi};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == S_DATA) remaining = bytes_left_q - 4'd1;
                    bytes_left_d = remaining;
                    if (remaining == 4'd0) begin
                        state_d = S_RAISE_CS;
                    end else if (byte_ready) begin
                        shift_d = byte_load;
                        tx_pop  = ~is_read;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (byte_ready) begin
                    shift_d   = byte_load;
                    tx_pop    = ~is_read;
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end else if (timeout_hit) begin
                    state_d = S_RAISE_CS;
                end
            end
            S_RAISE_CS: begin
                cs_n_d  = 1'b1;
                shift_d = 8'hFF;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (start_ok) err_d = 1'b0;
        if (tx_drop || rx_underflow || timeout_hit) err_d = 1'b1;
        len_d = len_q;
        if (WrStrobe && SelLen) len_d = len_sat;
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            cmd_q        <= 4'd0;
            len_q        <= 4'd0;
            bytes_left_q <= 4'd0;
            shift_q      <= 8'hFF;
            bit_cnt_q    <= 3'd0;
            cs_n_q       <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            bytes_left_q <= bytes_left_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            cs_n_q       <= cs_n_d;
            err_q        <= err_d;
        end
    end

    assign status = {~is_idle, ~rx_empty, tx_full, err_q, cmd_q};

    always_comb begin
        ReadData = 8'h00;
        if (SelCtrl)      ReadData = status;
        else if (SelData) ReadData = rx_empty ? 8'hFF : rx_head;
    end

    assign SPIDo         = shift_q[7];
    assign nMCUSel       = cs_n_q;
    assign SPIClkRunning = (state_q == S_CMD) || (state_q == S_DATA);
    assign SPIClkStretch = (state_q == S_WAIT);
endmodule
